// File: rtl/scmp_bus_pkg.sv
// rtl/scmp_bus_pkg.sv - shared widths, state type and address-match helper for the SC/MP bus controller
package scmp_bus_pkg;

    localparam int PAGE_W = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } bus_state_t;

    // A region whose mask is all zero is disabled and never matches.
    function automatic logic region_hit(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] mask
    );
        return (mask != '0) && ((addr & mask) == base);
    endfunction

endpackage

// File: rtl/scmp_region_decode.sv
// rtl/scmp_region_decode.sv - combinational priority decode of a 16-bit address into one-hot region selects
module scmp_region_decode
    import scmp_bus_pkg::*;
#(
    parameter int                            NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [NUM_REGIONS-1:0] sel,
    output logic                   hit
);

    // Region 0 sits in the leftmost slice of the packed tables. Scanning from the
    // highest index down lets the lowest matching index overwrite any later one.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (region_hit(addr,
                           REGION_BASE[(NUM_REGIONS-1-i)*ADDR_W +: ADDR_W],
                           REGION_MASK[(NUM_REGIONS-1-i)*ADDR_W +: ADDR_W])) begin
                sel    = '0;
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scmp_bus_ctrl.sv
// rtl/scmp_bus_ctrl.sv - SC/MP bus controller: page latch, region decode, wait states, read mux (SCMP_BUS_WPROT_EN adds write protect)
module scmp_bus_ctrl
    import scmp_bus_pkg::*;
#(
    parameter int                            NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h0000, 16'h1000, 16'hFFC0, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hF000, 16'hF000, 16'hFFC0, 16'h0000},
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = {4'd0, 4'd1, 4'd0, 4'd0},
    parameter logic [ADDR_W-1:0]             STATUS_ADDR = 16'hFD00,
    parameter logic [DATA_W-1:0]             OPEN_BUS    = 8'hFF,
    parameter logic [NUM_REGIONS-1:0]        WP_MASK     = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ads_n,
    input  logic                          rd_n,
    input  logic                          wr_n,
    input  logic [11:0]                   addr_lo,
    input  logic [DATA_W-1:0]             d_o,
    output logic [DATA_W-1:0]             d_i,
    output logic                          hold,
    output logic [PAGE_W-1:0]             page,
    output logic [3:0]                    flags,
    output logic [NUM_REGIONS-1:0]        sel,
    output logic [ADDR_W-1:0]             addr,
    output logic                          rd_en,
    output logic                          wr_en,
    output logic [DATA_W-1:0]             wdata,
    input  logic [DATA_W*NUM_REGIONS-1:0] rdata,
    input  logic [DATA_W-1:0]             status_i,
    output logic                          wp_err
);

`ifdef SCMP_BUS_WPROT_EN
    localparam logic [NUM_REGIONS-1:0] WP_EFF = WP_MASK;
`else
    localparam logic [NUM_REGIONS-1:0] WP_EFF = WP_MASK & '0;
`endif

    bus_state_t             state;
    logic [WAIT_W-1:0]      cnt;
    logic                   rd_q;
    logic                   wr_q;
    logic [NUM_REGIONS-1:0] sel_q;
    logic                   op_wr_q;
    logic                   acc_q;
    logic [NUM_REGIONS-1:0] dec_sel;
    logic                   dec_hit;
    logic                   is_status;
    logic                   start_rd;
    logic                   start_wr;
    logic [WAIT_W-1:0]      start_wait;
    logic [DATA_W-1:0]      sel_rdata;
    logic                   wp_block;

    assign addr      = {page, addr_lo};
    assign is_status = (addr == STATUS_ADDR);
    // A simultaneous read and write fall is a write; the read is dropped.
    assign start_wr  = wr_q & ~wr_n;
    assign start_rd  = rd_q & ~rd_n & ~start_wr;

    scmp_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decode (
        .addr (addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // Wait-state count of the region hit by the live address (region 0 is the leftmost slice).
    always_comb begin
        start_wait = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (dec_sel[i]) start_wait = REGION_WAIT[(NUM_REGIONS-1-i)*WAIT_W +: WAIT_W];
        end
    end

    // Read data of the region captured at access start (rdata is packed region 0 in the low byte).
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_q[i]) sel_rdata = sel_rdata | rdata[i*DATA_W +: DATA_W];
        end
    end

    assign wp_block = |(sel_q & WP_EFF);
    assign hold     = (state == WAIT) || (state == ACCESS);
    assign rd_en    = (state == ACCESS) && !op_wr_q;
    assign wr_en    = (state == ACCESS) && op_wr_q && !wp_block;
    // Idle cycles show the live decode; an access in flight keeps the select captured at its start.
    assign sel      = (state == IDLE) ? (is_status ? '0 : dec_sel) : sel_q;

    // Page nibble and flags follow d_o whenever the address strobe is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            page  <= '0;
            flags <= '0;
        end else if (!ads_n) begin
            page  <= d_o[3:0];
            flags <= d_o[7:4];
        end
    end

    // Previous strobe levels for edge detection; they only mirror the pins.
    always_ff @(posedge clk) begin
        rd_q <= rd_n;
        wr_q <= wr_n;
    end

    // Access sequencer: start on a strobe fall, count wait states, pulse the enable, then wait for release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_q   <= '0;
            op_wr_q <= 1'b0;
            acc_q   <= 1'b0;
            wdata   <= '0;
            d_i     <= OPEN_BUS;
        end else begin
            acc_q <= (state == ACCESS);
            case (state)
                IDLE: begin
                    if (start_rd || start_wr) begin
                        if (dec_hit && !is_status) begin
                            sel_q   <= dec_sel;
                            op_wr_q <= start_wr;
                            cnt     <= start_wait;
                            if (start_wr) wdata <= d_o;
                            state   <= (start_wait != '0) ? WAIT : ACCESS;
                        end else if (start_rd) begin
                            d_i <= is_status ? status_i : OPEN_BUS;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == WAIT_W'(1)) state <= ACCESS;
                end
                ACCESS: begin
                    state <= DONE;
                end
                DONE: begin
                    if (acc_q && !op_wr_q) d_i <= sel_rdata;
                    if (rd_n && wr_n) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCMP_BUS_WPROT_EN
    // Sticky record of a write that the protect mask blocked; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_err <= 1'b0;
        end else if (state == ACCESS && op_wr_q && wp_block) begin
            wp_err <= 1'b1;
        end
    end
`else
    assign wp_err = 1'b0;
`endif

endmodule

// File: tb/tb_scmp_bus_ctrl.sv
// tb/tb_scmp_bus_ctrl.sv - randomized and directed self-checking bench for scmp_bus_ctrl
`timescale 1ns/1ps
module tb_scmp_bus_ctrl;

    localparam int          NR     = 4;
    localparam logic [63:0] P_BASE = {16'h0000, 16'h1000, 16'hFFC0, 16'hFFC0};
    localparam logic [63:0] P_MASK = {16'hF000, 16'hF000, 16'hFFC0, 16'hFFF0};
    localparam logic [15:0] P_WAIT = {4'd0, 4'd1, 4'd2, 4'd0};
    localparam logic [3:0]  P_WP   = 4'b0001;
`ifdef SCMP_BUS_WPROT_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    // Region tables in region order (index 0 = region 0) for the reference model.
    logic [15:0] t_base [NR] = '{16'h0000, 16'h1000, 16'hFFC0, 16'hFFC0};
    logic [15:0] t_mask [NR] = '{16'hF000, 16'hF000, 16'hFFC0, 16'hFFF0};
    int          t_wait [NR] = '{0, 1, 2, 0};
    int          t_wp   [NR] = '{1, 0, 0, 0};

    logic        clk, rst, ads_n, rd_n, wr_n;
    logic [11:0] addr_lo;
    logic [7:0]  d_o, d_i, wdata, status_i;
    logic        hold, rd_en, wr_en, wp_err;
    logic [3:0]  page, flags, sel;
    logic [15:0] addr;
    logic [31:0] rdata;

    int checks = 0;
    int fails  = 0;

    scmp_bus_ctrl #(
        .NUM_REGIONS (NR),
        .REGION_BASE (P_BASE),
        .REGION_MASK (P_MASK),
        .REGION_WAIT (P_WAIT),
        .STATUS_ADDR (16'hFD00),
        .OPEN_BUS    (8'hFF),
        .WP_MASK     (P_WP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ads_n    (ads_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .addr_lo  (addr_lo),
        .d_o      (d_o),
        .d_i      (d_i),
        .hold     (hold),
        .page     (page),
        .flags    (flags),
        .sel      (sel),
        .addr     (addr),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wdata    (wdata),
        .rdata    (rdata),
        .status_i (status_i),
        .wp_err   (wp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Region memories: one-cycle latency, garbage on every cycle they are not read-enabled.
    logic [7:0] rd_val;
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++)
            rdata[i*8 +: 8] <= (rd_en && sel[i]) ? rd_val : 8'($urandom);
    end

    // ---------------- reference model ----------------
    function automatic int model_region(input logic [15:0] a);
        if (a == 16'hFD00) return -2;
        for (int i = 0; i < NR; i++)
            if (t_mask[i] != 16'h0 && ((a & t_mask[i]) == t_base[i])) return i;
        return -1;
    endfunction

    function automatic bit prot(input int r);
        return WP_ON && (t_wp[r] != 0);
    endfunction

    bit         m_ok = 1'b0, m_busy = 1'b0, m_wr = 1'b0, m_wp = 1'b0;
    bit         m_prev_rd = 1'b1, m_prev_wr = 1'b1;
    int         m_t = 0, m_w = 0, m_r = 0;
    logic [3:0] m_page = 4'h0, m_flags = 4'h0;
    logic [7:0] m_di = 8'hFF, m_wdata = 8'h00;

    // Access timeline: t counts edges since the fall was seen; hold spans t=1..w+1,
    // the enable fires at t=w+1, d_i takes the region data on the edge ending t=w+2.
    always @(posedge clk) begin : model
        int  r;
        bit  rf, wf;
        rf = m_prev_rd && !rd_n;
        wf = m_prev_wr && !wr_n;
        if (rst) begin
            m_ok = 1'b1; m_busy = 1'b0; m_page = 4'h0; m_flags = 4'h0;
            m_di = 8'hFF; m_wdata = 8'h00; m_wp = 1'b0;
        end else begin
            if (m_busy) begin
                if (m_t == m_w + 1 && m_wr && prot(m_r)) m_wp = 1'b1;
                if (m_t == m_w + 2 && !m_wr) m_di = rd_val;
                if (m_t >= m_w + 2 && rd_n && wr_n) m_busy = 1'b0;
                else m_t++;
            end else if (rf || wf) begin
                r = model_region({m_page, addr_lo});
                if (r >= 0) begin
                    m_busy = 1'b1; m_t = 1; m_r = r; m_w = t_wait[r]; m_wr = wf;
                    if (wf) m_wdata = d_o;
                end else if (!wf) begin
                    m_di = (r == -2) ? status_i : 8'hFF;
                end
            end
            if (!ads_n) begin
                m_page  = d_o[3:0];
                m_flags = d_o[7:4];
            end
        end
        m_prev_rd = rd_n;
        m_prev_wr = wr_n;
    end

    // Per-cycle compare against the model, plus counters for the directed scenarios.
    int         n_hold = 0, n_rd = 0, n_wr = 0;
    logic [3:0] sel_at_en = 4'h0;
    logic [7:0] wdata_at_en = 8'h00;
    always @(negedge clk) begin : compare
        int         r;
        logic [3:0] es;
        if (m_ok) begin
            if (m_busy) es = 4'(1 << m_r);
            else begin
                r  = model_region({m_page, addr_lo});
                es = (r >= 0) ? 4'(1 << r) : 4'h0;
            end
            check("hold",   32'(hold),   32'(m_busy && m_t <= m_w + 1));
            check("rd_en",  32'(rd_en),  32'(m_busy && !m_wr && m_t == m_w + 1));
            check("wr_en",  32'(wr_en),  32'(m_busy && m_wr && m_t == m_w + 1 && !prot(m_r)));
            check("sel",    32'(sel),    32'(es));
            check("d_i",    32'(d_i),    32'(m_di));
            check("page",   32'(page),   32'(m_page));
            check("flags",  32'(flags),  32'(m_flags));
            check("addr",   32'(addr),   32'({m_page, addr_lo}));
            check("wdata",  32'(wdata),  32'(m_wdata));
            check("wp_err", 32'(wp_err), 32'(m_wp));
        end
        n_hold += int'(hold);
        n_rd   += int'(rd_en);
        n_wr   += int'(wr_en);
        if (rd_en || wr_en) begin
            sel_at_en   = sel;
            wdata_at_en = wdata;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ads(input logic [7:0] v);
        ads_n = 1'b0; d_o = v; tick(1); ads_n = 1'b1;
    endtask

    task automatic clr();
        n_hold = 0; n_rd = 0; n_wr = 0; sel_at_en = 4'h0; wdata_at_en = 8'h00;
    endtask

    task automatic access(input bit wr, input logic [11:0] a, input logic [7:0] v, input int low);
        addr_lo = a;
        if (wr) begin d_o = v; wr_n = 1'b0; end
        else begin rd_val = v; rd_n = 1'b0; end
        tick(low);
        rd_n = 1'b1; wr_n = 1'b1;
        tick(2);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ads_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr_lo = 12'h000; d_o = 8'h00; status_i = 8'h00; rd_val = 8'h00;
        tick(3);
        check("rst_page",  32'(page),   32'h0);
        check("rst_flags", 32'(flags),  32'h0);
        check("rst_hold",  32'(hold),   32'h0);
        check("rst_d_i",   32'(d_i),    32'hFF);
        check("rst_wdata", 32'(wdata),  32'h00);
        check("rst_wp",    32'(wp_err), 32'h0);
        rst = 1'b0;
        tick(1);

        // Read of 0x1234, region 1, one wait state.
        ads(8'h51);
        check("t1_page",  32'(page),  32'h1);
        check("t1_flags", 32'(flags), 32'h5);
        clr();
        access(1'b0, 12'h234, 8'h3C, 6);
        check("t1_hold", 32'(n_hold),    32'd2);
        check("t1_rd",   32'(n_rd),      32'd1);
        check("t1_sel",  32'(sel_at_en), 32'b0010);
        check("t1_d_i",  32'(d_i),       32'h3C);

        // Write to 0x0010, region 0, zero wait, strobe held low 5 cycles.
        ads(8'h00);
        clr();
        access(1'b1, 12'h010, 8'hA5, 5);
        check("t2_hold",  32'(n_hold),      32'd1);
        check("t2_wr",    32'(n_wr),        32'd1 - 32'(WP_ON));
        check("t2_wdata", 32'(wdata),       32'hA5);
        check("t2_sel",   32'(sel_at_en),   WP_ON ? 32'h0 : 32'b0001);

        // Status read at 0xFD00, then open-bus read at 0x8000.
        ads(8'h0F);
        status_i = 8'h80;
        clr();
        addr_lo = 12'hD00; rd_n = 1'b0;
        tick(1);
        check("t3_status", 32'(d_i), 32'h80);
        check("t3_sel",    32'(sel), 32'h0);
        tick(2); rd_n = 1'b1; tick(1);
        check("t3_hold", 32'(n_hold), 32'd0);
        check("t3_rd",   32'(n_rd),   32'd0);
        ads(8'h08);
        addr_lo = 12'h000; rd_n = 1'b0;
        tick(1);
        check("t3_open", 32'(d_i), 32'hFF);
        rd_n = 1'b1; tick(1);

        // 0xFFC5 overlaps regions 2 and 3; region 2 (two waits) wins.
        ads(8'h0F);
        clr();
        access(1'b0, 12'hFC5, 8'h6E, 6);
        check("t4_sel",  32'(sel_at_en), 32'b0100);
        check("t4_hold", 32'(n_hold),    32'd3);
        check("t4_d_i",  32'(d_i),       32'h6E);

        // Reset during the wait state of a region-1 read.
        ads(8'h51);
        clr();
        addr_lo = 12'h234; rd_val = 8'h11; rd_n = 1'b0;
        tick(1);
        check("t5_hold_wait", 32'(hold), 32'h1);
        rst = 1'b1; rd_n = 1'b1;
        tick(1);
        check("t5_hold_rst", 32'(hold),  32'h0);
        check("t5_rd_rst",   32'(rd_en), 32'h0);
        rst = 1'b0;
        tick(2);
        check("t5_no_rd", 32'(n_rd), 32'd0);
        ads(8'h51);
        clr();
        access(1'b0, 12'h234, 8'h99, 6);
        check("t5_rd_after", 32'(n_rd), 32'd1);
        check("t5_d_i",      32'(d_i),  32'h99);

`ifdef SCMP_BUS_WPROT_EN
        // Protected write to 0x0005, then a legal write to 0x1010.
        ads(8'h00);
        clr();
        access(1'b1, 12'h005, 8'h12, 4);
        check("t6_wr",   32'(n_wr),   32'd0);
        check("t6_hold", 32'(n_hold), 32'd1);
        check("t6_wp",   32'(wp_err), 32'h1);
        ads(8'h01);
        clr();
        access(1'b1, 12'h010, 8'h34, 4);
        check("t6_wr_ok",    32'(n_wr),   32'd1);
        check("t6_wp_stick", 32'(wp_err), 32'h1);
`endif

        // Randomized traffic: mixed pages, strobe lengths, ADS and reset mid-access.
        for (int k = 0; k < 400; k++) begin
            int op, low, pg;
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 3))
                    0:       pg = 0;
                    1:       pg = 1;
                    2:       pg = 15;
                    default: pg = int'($urandom_range(0, 15));
                endcase
                ads({4'($urandom), 4'(pg)});
            end
            case ($urandom_range(0, 3))
                0:       addr_lo = 12'hD00;
                1:       addr_lo = 12'hFC0 | 12'($urandom_range(0, 63));
                2:       addr_lo = 12'($urandom_range(0, 255));
                default: addr_lo = 12'($urandom);
            endcase
            status_i = 8'($urandom);
            rd_val   = 8'($urandom);
            d_o      = 8'($urandom);
            op       = int'($urandom_range(0, 4));
            low      = int'($urandom_range(1, 8));
            if (op != 1) rd_n = 1'b0;
            if (op >= 1 && op <= 2) wr_n = 1'b0;
            for (int j = 0; j < low; j++) begin
                tick(1);
                ads_n = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
                if (!ads_n) d_o = 8'($urandom);
                rst = ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0;
            end
            tick(1);
            ads_n = 1'b1; rst = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
            tick(int'($urandom_range(1, 3)));
        end

        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
